// File: rtl/hls_chn_o_mc_wait_ctrl_if.sv
// Core-side and downstream-side signal bundle for the multi-channel chn_o wait controller.
// The slave modport is the controller's view; the master modport is the core/downstream view.
interface hls_chn_o_mc_wait_ctrl_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic                      core_wen;
    logic                      core_wten;
    logic [NUM_CH-1:0]         chn_o_iswt;
    logic [NUM_CH*DATA_W-1:0]  chn_o_idat;
    logic [NUM_CH-1:0]         chn_o_ld_core_sct;
    logic                      chn_o_stall;
    logic [NUM_CH-1:0]         chn_o_vld;
    logic [NUM_CH-1:0]         chn_o_rdy;
    logic [NUM_CH*DATA_W-1:0]  chn_o_dat;
    logic [NUM_CH*OCC_W-1:0]   chn_o_occ;

    modport slave (
        input  core_wen, core_wten, chn_o_iswt, chn_o_idat, chn_o_rdy,
        output chn_o_ld_core_sct, chn_o_stall, chn_o_vld, chn_o_dat, chn_o_occ
    );

    modport master (
        output core_wen, core_wten, chn_o_iswt, chn_o_idat, chn_o_rdy,
        input  chn_o_ld_core_sct, chn_o_stall, chn_o_vld, chn_o_dat, chn_o_occ
    );
endinterface

// File: rtl/hls_chn_o_mc_wait_ctrl.sv
// Multi-channel chn_o wait controller: per-channel DEPTH-entry skid FIFOs with all-or-nothing core commit.
// Optional macro HLS_CHN_O_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter output.
module hls_chn_o_mc_wait_ctrl #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
`ifdef HLS_CHN_O_STALL_CNT_EN
    output logic [15:0]                chn_o_stall_cnt,
`endif
    hls_chn_o_mc_wait_ctrl_if.slave    io
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem_q  [NUM_CH][DEPTH];
    logic [DATA_W-1:0] mem_d  [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  head_q [NUM_CH];
    logic [PTR_W-1:0]  head_d [NUM_CH];
    logic [PTR_W-1:0]  tail_q [NUM_CH];
    logic [PTR_W-1:0]  tail_d [NUM_CH];
    logic [OCC_W-1:0]  occ_q  [NUM_CH];
    logic [OCC_W-1:0]  occ_d  [NUM_CH];

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] blk;
    logic [NUM_CH-1:0] ld;
    logic              stall;

    // A full channel is only blocking if it is not draining this same cycle.
    always_comb begin
        req = '0;
        pop = '0;
        blk = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req[i] = io.chn_o_iswt[i] & io.core_wen & ~io.core_wten;
            pop[i] = (occ_q[i] != '0) & io.chn_o_rdy[i];
            blk[i] = req[i] & (occ_q[i] == OCC_FULL) & ~pop[i];
        end
        stall = |blk;
        ld    = req & {NUM_CH{~stall}};
    end

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ld[i]) begin
                mem_d[i][tail_q[i]] = io.chn_o_idat[i*DATA_W +: DATA_W];
                tail_d[i]           = tail_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                head_d[i] = head_q[i] + PTR_W'(1);
            end
            case ({ld[i], pop[i]})
                2'b10:   occ_d[i] = occ_q[i] + OCC_W'(1);
                2'b01:   occ_d[i] = occ_q[i] - OCC_W'(1);
                default: occ_d[i] = occ_q[i];
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_q[i][j] <= '0;
                end
                head_q[i] <= '0;
                tail_q[i] <= '0;
                occ_q[i]  <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Downstream side sees only registered state: no idat-to-dat bypass.
    always_comb begin
        io.chn_o_stall       = stall;
        io.chn_o_ld_core_sct = ld;
        io.chn_o_vld         = '0;
        io.chn_o_dat         = '0;
        io.chn_o_occ         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            io.chn_o_vld[i]                   = (occ_q[i] != '0);
            io.chn_o_dat[i*DATA_W +: DATA_W]  = mem_q[i][head_q[i]];
            io.chn_o_occ[i*OCC_W +: OCC_W]    = occ_q[i];
        end
    end

`ifdef HLS_CHN_O_STALL_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign chn_o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_hls_chn_o_mc_wait_ctrl.sv
// Self-checking bench for hls_chn_o_mc_wait_ctrl: vector table, corner-case sequences, random vs queue model.
module tb_hls_chn_o_mc_wait_ctrl;
    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hls_chn_o_mc_wait_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) io ();

`ifdef HLS_CHN_O_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    hls_chn_o_mc_wait_ctrl #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
`ifdef HLS_CHN_O_STALL_CNT_EN
        .chn_o_stall_cnt (stall_cnt),
`endif
        .io              (io)
    );

    int n_pass = 0;
    int n_tot  = 0;

    logic [15:0] mq0[$];
    logic [15:0] mq1[$];

    typedef struct {
        logic        wen;
        logic        wten;
        logic [1:0]  iswt;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  rdy;
        logic [1:0]  e_ld;
        logic        e_stall;
        logic [1:0]  e_vld;
        logic [1:0]  e_occ0;
        logic [1:0]  e_occ1;
        logic [15:0] e_dat0;
        logic [15:0] e_dat1;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Apply inputs at the falling edge and settle; checks then land mid-cycle.
    task automatic drive(input logic wen, input logic wten, input logic [1:0] iswt,
                         input logic [15:0] d0, input logic [15:0] d1, input logic [1:0] rdy);
        @(negedge clk);
        io.core_wen   = wen;
        io.core_wten  = wten;
        io.chn_o_iswt = iswt;
        io.chn_o_idat = {d1, d0};
        io.chn_o_rdy  = rdy;
        #1;
    endtask

    function automatic logic [1:0] occ0(); return io.chn_o_occ[1:0]; endfunction
    function automatic logic [1:0] occ1(); return io.chn_o_occ[3:2]; endfunction
    function automatic logic [15:0] dat0(); return io.chn_o_dat[15:0]; endfunction
    function automatic logic [15:0] dat1(); return io.chn_o_dat[31:16]; endfunction

    initial begin
        logic        r_wen, r_wten, req0, req1, pop0, pop1, blk0, blk1, e_stall;
        logic [1:0]  r_iswt, r_rdy, e_ld;
        logic [15:0] r_d0, r_d1;

        tbl[0]  = '{1'b1, 1'b0, 2'b01, 16'h000A, 16'h0000, 2'b00, 2'b01, 1'b0, 2'b00, 2'd0, 2'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 2'b01, 16'h000B, 16'h0000, 2'b00, 2'b01, 1'b0, 2'b01, 2'd1, 2'd0, 16'h000A, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 2'b11, 16'h000C, 16'h0055, 2'b00, 2'b00, 1'b1, 2'b01, 2'd2, 2'd0, 16'h000A, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 2'b11, 16'h000C, 16'h0055, 2'b00, 2'b00, 1'b1, 2'b01, 2'd2, 2'd0, 16'h000A, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 2'b11, 16'h000C, 16'h0055, 2'b01, 2'b11, 1'b0, 2'b01, 2'd2, 2'd0, 16'h000A, 16'h0000};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b11, 2'd2, 2'd1, 16'h000B, 16'h0055};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b11, 2'b00, 1'b0, 2'b11, 2'd2, 2'd1, 16'h000B, 16'h0055};
        tbl[7]  = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b01, 2'd1, 2'd0, 16'h000C, 16'h0000};
        tbl[8]  = '{1'b1, 1'b1, 2'b11, 16'h0007, 16'h0007, 2'b01, 2'b00, 1'b0, 2'b01, 2'd1, 2'd0, 16'h000C, 16'h0000};
        tbl[9]  = '{1'b0, 1'b0, 2'b11, 16'h0007, 16'h0007, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 16'h0000, 16'h0000};
        tbl[10] = '{1'b1, 1'b0, 2'b11, 16'h0001, 16'h0002, 2'b00, 2'b11, 1'b0, 2'b00, 2'd0, 2'd0, 16'h0000, 16'h0000};
        tbl[11] = '{1'b1, 1'b0, 2'b11, 16'h0003, 16'h0004, 2'b00, 2'b11, 1'b0, 2'b11, 2'd1, 2'd1, 16'h0001, 16'h0002};
        tbl[12] = '{1'b1, 1'b1, 2'b11, 16'h0005, 16'h0006, 2'b00, 2'b00, 1'b0, 2'b11, 2'd2, 2'd2, 16'h0001, 16'h0002};
        tbl[13] = '{1'b0, 1'b0, 2'b11, 16'h0005, 16'h0006, 2'b00, 2'b00, 1'b0, 2'b11, 2'd2, 2'd2, 16'h0001, 16'h0002};
        tbl[14] = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b11, 2'd2, 2'd2, 16'h0001, 16'h0002};
        tbl[15] = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b11, 2'b00, 1'b0, 2'b11, 2'd2, 2'd2, 16'h0001, 16'h0002};
        tbl[16] = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b11, 2'b00, 1'b0, 2'b11, 2'd1, 2'd1, 16'h0003, 16'h0004};
        tbl[17] = '{1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b0, 2'b00, 2'd0, 2'd0, 16'h0000, 16'h0000};

        io.core_wen = 1'b0; io.core_wten = 1'b0; io.chn_o_iswt = '0; io.chn_o_idat = '0; io.chn_o_rdy = '0;

        // Reset values
        @(negedge clk); @(negedge clk); #1;
        chk("rst_vld",   32'(io.chn_o_vld), 32'h0);
        chk("rst_dat",   io.chn_o_dat, 32'h0);
        chk("rst_occ",   32'(io.chn_o_occ), 32'h0);
        chk("rst_stall", 32'(io.chn_o_stall), 32'h0);
        chk("rst_ld",    32'(io.chn_o_ld_core_sct), 32'h0);
`ifdef HLS_CHN_O_STALL_CNT_EN
        chk("rst_cnt",   32'(stall_cnt), 32'h0);
`endif
        @(negedge clk); rstn = 1'b1;

        // Single push held until ready
        drive(1'b1, 1'b0, 2'b01, 16'h1234, 16'h0, 2'b00);
        chk("p1_ld", 32'(io.chn_o_ld_core_sct), 32'h1);
        chk("p1_vld_nobypass", 32'(io.chn_o_vld), 32'h0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
            chk("p1_hold_vld", 32'(io.chn_o_vld), 32'h1);
            chk("p1_hold_dat", 32'(dat0()), 32'h1234);
            chk("p1_hold_occ", 32'(occ0()), 32'h1);
        end
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b01);
        chk("p1_pop_vld", 32'(io.chn_o_vld), 32'h1);
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        chk("p1_after_vld", 32'(io.chn_o_vld), 32'h0);
        chk("p1_after_occ", 32'(occ0()), 32'h0);

        // Streaming through a full channel with pointer wrap
        drive(1'b1, 1'b0, 2'b01, 16'h1, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'b01, 16'h2, 16'h0, 2'b00);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, (k + 3 <= 8) ? 2'b01 : 2'b00, 16'(k + 3), 16'h0, 2'b01);
            chk("str_dat",   32'(dat0()), 32'(k + 1));
            chk("str_occ",   32'(occ0()), (k <= 6) ? 32'd2 : 32'd1);
            chk("str_stall", 32'(io.chn_o_stall), 32'h0);
            if (k + 3 <= 8) chk("str_ld", 32'(io.chn_o_ld_core_sct), 32'h1);
        end
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        chk("str_end_vld", 32'(io.chn_o_vld), 32'h0);

        // Asynchronous reset with buffered data
        drive(1'b1, 1'b0, 2'b01, 16'hAA, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'b01, 16'hBB, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        chk("ar_pre_occ", 32'(occ0()), 32'h2);
        #2 rstn = 1'b0;
        #1;
        chk("ar_vld", 32'(io.chn_o_vld), 32'h0);
        chk("ar_occ", 32'(io.chn_o_occ), 32'h0);
        chk("ar_dat", io.chn_o_dat, 32'h0);
        @(negedge clk); rstn = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b11);
        chk("ar_post_vld", 32'(io.chn_o_vld), 32'h0);

        // Vector table: stall/commit, ordering, wten/wen masking
        for (int v = 0; v < 18; v++) begin
            drive(tbl[v].wen, tbl[v].wten, tbl[v].iswt, tbl[v].d0, tbl[v].d1, tbl[v].rdy);
            chk($sformatf("t%0d_ld", v),    32'(io.chn_o_ld_core_sct), 32'(tbl[v].e_ld));
            chk($sformatf("t%0d_stall", v), 32'(io.chn_o_stall),       32'(tbl[v].e_stall));
            chk($sformatf("t%0d_vld", v),   32'(io.chn_o_vld),         32'(tbl[v].e_vld));
            chk($sformatf("t%0d_occ0", v),  32'(occ0()),               32'(tbl[v].e_occ0));
            chk($sformatf("t%0d_occ1", v),  32'(occ1()),               32'(tbl[v].e_occ1));
            if (tbl[v].e_vld[0]) chk($sformatf("t%0d_dat0", v), 32'(dat0()), 32'(tbl[v].e_dat0));
            if (tbl[v].e_vld[1]) chk($sformatf("t%0d_dat1", v), 32'(dat1()), 32'(tbl[v].e_dat1));
        end

        // Random traffic against a queue model
        mq0.delete();
        mq1.delete();
        for (int n = 0; n < 400; n++) begin
            r_wen  = ($urandom_range(3) != 0);
            r_wten = ($urandom_range(5) == 0);
            r_iswt = 2'($urandom_range(3));
            r_d0   = 16'($urandom);
            r_d1   = 16'($urandom);
            r_rdy  = {($urandom_range(2) != 0), ($urandom_range(2) != 0)};
            drive(r_wen, r_wten, r_iswt, r_d0, r_d1, r_rdy);

            req0 = r_iswt[0] && r_wen && !r_wten;
            req1 = r_iswt[1] && r_wen && !r_wten;
            pop0 = (mq0.size() > 0) && r_rdy[0];
            pop1 = (mq1.size() > 0) && r_rdy[1];
            blk0 = req0 && (mq0.size() == DEPTH) && !pop0;
            blk1 = req1 && (mq1.size() == DEPTH) && !pop1;
            e_stall = blk0 || blk1;
            e_ld = {req1 && !e_stall, req0 && !e_stall};

            chk("rnd_stall", 32'(io.chn_o_stall), 32'(e_stall));
            chk("rnd_ld",    32'(io.chn_o_ld_core_sct), 32'(e_ld));
            chk("rnd_vld",   32'(io.chn_o_vld), 32'({mq1.size() != 0, mq0.size() != 0}));
            chk("rnd_occ0",  32'(occ0()), 32'(mq0.size()));
            chk("rnd_occ1",  32'(occ1()), 32'(mq1.size()));
            if (mq0.size() != 0) chk("rnd_dat0", 32'(dat0()), 32'(mq0[0]));
            if (mq1.size() != 0) chk("rnd_dat1", 32'(dat1()), 32'(mq1[0]));

            if (pop0) void'(mq0.pop_front());
            if (pop1) void'(mq1.pop_front());
            if (e_ld[0]) mq0.push_back(r_d0);
            if (e_ld[1]) mq1.push_back(r_d1);
        end

`ifdef HLS_CHN_O_STALL_CNT_EN
        drive(1'b0, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        rstn = 1'b0;
        #1;
        chk("cnt_rst", 32'(stall_cnt), 32'h0);
        @(negedge clk); rstn = 1'b1;
        drive(1'b1, 1'b0, 2'b01, 16'h1, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'b01, 16'h2, 16'h0, 2'b00);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 2'b01, 16'h3, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        chk("cnt_3", 32'(stall_cnt), 32'h3);
        for (int k = 0; k < 70000; k++) drive(1'b1, 1'b0, 2'b01, 16'h3, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 2'b00);
        chk("cnt_sat", 32'(stall_cnt), 32'hFFFF);
        rstn = 1'b0;
        #1;
        chk("cnt_rst2", 32'(stall_cnt), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
